// File: rtl/stream_merge_pkg.sv
// rtl/stream_merge_pkg.sv - shared lane count, pointer width and lane compaction helpers
package stream_merge_pkg;

  localparam int LANES = 4;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Output slot of a lane = number of valid lanes below it.
  function automatic logic [1:0] lane_slot(input logic [LANES-1:0] valid, input int lane);
    logic [1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      if (i < lane && valid[i]) cnt = cnt + 2'd1;
    end
    return cnt;
  endfunction

  function automatic logic [2:0] popcount4(input logic [LANES-1:0] valid);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + 3'(valid[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lane_compact4.sv
// rtl/lane_compact4.sv - packs the valid lanes into consecutive slots, lane 0 first
module lane_compact4
  import stream_merge_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [LANES-1:0][DATA_W-1:0] lane_data,
  input  logic [LANES-1:0]             lane_valid,
  output logic [LANES-1:0][DATA_W-1:0] slot_data,
  output logic [2:0]                   npush
);

  always_comb begin
    slot_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_valid[i]) slot_data[lane_slot(lane_valid, i)] = lane_data[i];
    end
  end

  assign npush = popcount4(lane_valid);

endmodule

// File: rtl/stream_merge_4to1.sv
// rtl/stream_merge_4to1.sv - merges four lanes into one valid/ready stream through a circular FIFO
// Optional drop_cnt port/counter when STREAM_MERGE_DROP_CNT_EN is defined.
module stream_merge_4to1
  import stream_merge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [DATA_W-1:0]       in_0,
  input  logic [DATA_W-1:0]       in_1,
  input  logic [DATA_W-1:0]       in_2,
  input  logic [DATA_W-1:0]       in_3,
  input  logic                    in_valid_0,
  input  logic                    in_valid_1,
  input  logic                    in_valid_2,
  input  logic                    in_valid_3,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level
`ifdef STREAM_MERGE_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0]             mem [DEPTH];
  logic [PW-1:0]                 rd_ptr;
  logic [PW-1:0]                 wr_ptr;
  logic [LANES-1:0]              lane_valid;
  logic [LANES-1:0][DATA_W-1:0]  lane_data;
  logic [LANES-1:0][DATA_W-1:0]  slot_data;
  logic [2:0]                    npush;
  logic [2:0]                    npush_acc;
  logic                          pop;
  logic [LW-1:0]                 level_next;

  assign lane_valid = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
  assign lane_data  = {in_3, in_2, in_1, in_0};

  lane_compact4 #(.DATA_W(DATA_W)) u_compact (
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .slot_data  (slot_data),
    .npush      (npush)
  );

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    npush_acc  = in_ready ? npush : 3'd0;
    pop        = out_valid & out_ready;
    level_next = level + LW'(npush_acc) - LW'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(npush_acc);
      rd_ptr   <= rd_ptr + PW'(pop);
      level    <= level_next;
      in_ready <= (LW'(DEPTH) - level_next) >= LW'(LANES);
    end
  end

  // Storage needs no reset: only words between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk_in) begin
    if (reset_in && in_ready) begin
      for (int j = 0; j < LANES; j++) begin
        if (3'(j) < npush) mem[wr_ptr + PW'(j)] <= slot_data[j];
      end
    end
  end

`ifdef STREAM_MERGE_DROP_CNT_EN
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt} + 17'(npush);

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      drop_cnt <= '0;
    end else if (!in_ready) begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_stream_merge_4to1.sv
// tb/tb_stream_merge_4to1.sv - directed self-checking bench for stream_merge_4to1
module tb_stream_merge_4to1;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [7:0] in_0, in_1, in_2, in_3;
  logic       in_valid_0, in_valid_1, in_valid_2, in_valid_3;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
`ifdef STREAM_MERGE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  stream_merge_4to1 #(.DATA_W(8), .DEPTH(16)) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .in_0       (in_0),
    .in_1       (in_1),
    .in_2       (in_2),
    .in_3       (in_3),
    .in_valid_0 (in_valid_0),
    .in_valid_1 (in_valid_1),
    .in_valid_2 (in_valid_2),
    .in_valid_3 (in_valid_3),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level)
`ifdef STREAM_MERGE_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = v;
    in_0 = d0;
    in_1 = d1;
    in_2 = d2;
    in_3 = d3;
  endtask

  task automatic check_out(input string tag, input logic [7:0] data, input logic vld,
                           input logic [4:0] lvl);
    check({tag, "_data"}, 32'(out_data), 32'(data));
    check({tag, "_valid"}, 32'(out_valid), 32'(vld));
    check({tag, "_level"}, 32'(level), 32'(lvl));
  endtask

  initial begin
    reset_in  = 1'b0;
    out_ready = 1'b0;
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;

    // Reset held for three edges
    repeat (3) step();
    check_out("reset", 8'h00, 1'b0, 5'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    reset_in = 1'b1;
    step();
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_level", 32'(level), 32'd0);

    // Full burst, consumer always ready
    out_ready = 1'b1;
    drive(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    step();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      check_out($sformatf("burst%0d", k), 8'(k + 1), 1'b1, 5'(4 - k));
      step();
    end
    check_out("burst_empty", 8'h00, 1'b0, 5'd0);

    // Sparse lanes 1 and 3
    drive(4'b1010, 8'h55, 8'hAA, 8'h55, 8'hBB);
    step();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    check_out("sparse0", 8'hAA, 1'b1, 5'd2);
    step();
    check_out("sparse1", 8'hBB, 1'b1, 5'd1);
    step();
    check_out("sparse_empty", 8'h00, 1'b0, 5'd0);

    // Fill to 16 with output stalled, then a dropped cycle
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 8'(4*c), 8'(4*c + 1), 8'(4*c + 2), 8'(4*c + 3));
      step();
    end
    check("fill_level", 32'(level), 32'd16);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_head", 32'(out_data), 32'h00);
    drive(4'b1111, 8'hF0, 8'hF1, 8'hF2, 8'hF3);
    step();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    check("drop_level", 32'(level), 32'd16);
    check("drop_head", 32'(out_data), 32'h00);
`ifdef STREAM_MERGE_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'd4);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_out($sformatf("drain%0d", k), 8'(k), 1'b1, 5'(16 - k));
      check($sformatf("drain%0d_in_ready", k), 32'(in_ready), 32'((16 - k) <= 12));
      step();
    end
    check_out("drain_empty", 8'h00, 1'b0, 5'd0);

    // Reach level 12, then push 4 and pop 1 on the same edge
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, 8'(8'h20 + 4*c), 8'(8'h21 + 4*c), 8'(8'h22 + 4*c), 8'(8'h23 + 4*c));
      step();
    end
    check("sim_pre_level", 32'(level), 32'd12);
    check("sim_pre_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(4'b1111, 8'h30, 8'h31, 8'h32, 8'h33);
    step();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    check("sim_level", 32'(level), 32'd15);
    check("sim_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 15; k++) begin
      check($sformatf("sim_order%0d", k), 32'(out_data),
            32'((k < 11) ? (8'h21 + k) : (8'h30 + k - 11)));
      step();
    end
    check_out("sim_empty", 8'h00, 1'b0, 5'd0);

    // Reset with nine words buffered
    out_ready = 1'b0;
    drive(4'b1111, 8'h40, 8'h41, 8'h42, 8'h43);
    step();
    drive(4'b1111, 8'h44, 8'h45, 8'h46, 8'h47);
    step();
    drive(4'b0001, 8'h48, 8'h00, 8'h00, 8'h00);
    step();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    check("mid_level", 32'(level), 32'd9);
    reset_in = 1'b0;
    step();
    reset_in = 1'b1;
    check_out("mid_reset", 8'h00, 1'b0, 5'd0);
    check("mid_reset_in_ready", 32'(in_ready), 32'd0);
    step();
    check("mid_release_in_ready", 32'(in_ready), 32'd1);
    drive(4'b0100, 8'h66, 8'h66, 8'h77, 8'h66);
    step();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    check_out("post_reset", 8'h77, 1'b1, 5'd1);
    out_ready = 1'b1;
    step();
    check_out("post_reset_empty", 8'h00, 1'b0, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_merge_4to1.md
Name: stream_merge_4to1

Overview:
- Reverse path of the 4-lane splitter: collects up to four lane words per cycle (out_k/out_valid_k style lanes) and re-serialises them into one valid/ready stream.
- Lanes with the lower index are emitted first; a circular FIFO absorbs the 4:1 rate mismatch.
- Sits after the lane-producing stage. Feeds any single-stream consumer that applies backpressure.

Parameters:
- DATA_W, 8, word width of every lane and of the output.
- DEPTH, 16, FIFO depth in words. Must be a power of two and >= 8.

Ports:
- clk_in  input  1  single clock; all logic uses its rising edge.
- reset_in  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk_in).
- in_0..in_3  input  DATA_W each  lane data.
- in_valid_0..in_valid_3  input  1 each  lane valid, independent per lane.
- in_ready  output  1  registered. When high, every valid lane in this cycle is accepted.
- out_data  output  DATA_W  head word of the FIFO.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accept.
- level  output  $clog2(DEPTH)+1  current word count, registered.

Behaviour:
- Reset (reset_in=0 at an edge):
  - rd_ptr=0, wr_ptr=0, level=0, in_ready=0.
  - out_valid=0 and out_data=0.
  - Memory contents are don't-care and never emitted.
- in_ready:
  - Registered as (DEPTH - level_next) >= 4.
  - Rises on the first edge after reset_in returns high.
- Push:
  - Occurs when in_ready=1. The valid lanes are compacted in order 0,1,2,3 and written to wr_ptr, wr_ptr+1, ...
  - npush = popcount(in_valid_*), range 0..4. wr_ptr advances by npush modulo DEPTH.
- Drop:
  - Valid lanes presented while in_ready=0 are discarded. The source has no stall, so this is by design.
  - State is unchanged by a dropped cycle.
- Pop:
  - pop = out_valid & out_ready. rd_ptr advances by 1 modulo DEPTH.
  - out_valid = (level != 0). out_data = mem[rd_ptr] when out_valid, else 0.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Latency:
  - A word written at edge N is visible on out_data after edge N.
  - If the FIFO was empty, it is presented in the cycle after its lane was valid. There is no same-cycle bypass.
- Simultaneous push and pop: level_next = level + npush - pop, with all terms applied in the same edge.
- Overflow is impossible, because in_ready guarantees 4 free slots. Underflow is impossible, because pop requires out_valid.
- Pointers wrap naturally at DEPTH. Full is level==DEPTH; empty is level==0.
- A reset mid-operation discards all buffered words. The first output after reset is the first word accepted after reset.

Optional Feature:
- Macro: STREAM_MERGE_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt (16 bit).
  - Increments by popcount(in_valid_*) on every cycle with in_ready=0, saturating at 16'hFFFF.
  - Cleared by reset.
- Undefined: no port and no counter. Drops are silent; all other behaviour is identical.

Decomposition:
- Package stream_merge_pkg holds:
  - LANES=4.
  - A localparam function for pointer width ($clog2(DEPTH)).
  - The popcount/prefix function used for lane compaction.
- One sub-module, lane_compact4 (combinational): takes 4 data words and 4 valid bits. It returns the compacted words (slot 0 first) and npush.
- The top level owns the memory, pointers, level, in_ready register and drop counter.

Test Plan:
- Reset: hold reset_in=0 for 3 cycles.
  - Required: in_ready=0, out_valid=0, out_data=00, level=0.
  - Release: in_ready=1 one edge later.
- Full burst with out_ready=1: one cycle of lanes 01,02,03,04, all valid.
  - Required: out_data 01,02,03,04 on 4 consecutive cycles starting the next cycle.
  - Required: level 4,3,2,1, then 0.
- Sparse lanes: only lanes 1 and 3 valid (AA, BB), lanes 0 and 2 carrying 55.
  - Required: output AA then BB. 55 is never seen; level peaks at 2.
- Fill and drop: out_ready=0 with 4 full-lane cycles (00..0F).
  - Required: level=16, in_ready=0.
  - A 5th cycle (F0..F3) is dropped; with the macro defined, drop_cnt=4.
  - Then out_ready=1: 00..0F emitted in order, with in_ready back to 1 once level<=12.
- Simultaneous: level=12, push 4 and pop 1 in the same cycle.
  - Required: level=15, in_ready=0, order preserved.
- Reset mid-operation: level=9, then reset_in=0 for 1 cycle.
  - Required: level=0, out_valid=0.
  - The next accepted word 77 is the first output; no stale words appear.
